// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Data-memory access stage for an RV32I core. Takes the execute-stage address
// (alu_out) and store data (rs2), turns LB/LH/LW/LBU/LHU/SB/SH/SW into a
// word-aligned, byte-enabled request to a variable-latency data memory
// (mem_req held until mem_ack), extends the returned load data, and stalls
// the core until the access completes, times out or is rejected.
//
// Build option:
//   MISALIGN_TRAP_EN  defined   -> LH/LHU/SH with addr[0]=1 and LW/SW with
//                                  addr[1:0]!=0 are rejected (rsp_err=1, no
//                                  memory access).
//                     undefined -> no trap; the low address bits below the
//                                  access size are ignored.
//
// Ports:
//   clk, reset         rising-edge clock; asynchronous active-low reset
//   req_valid/ready    core request handshake (accepted when both high)
//   req_we/fn3/addr/wdata  request fields, registered on acceptance
//   rsp_valid          one-cycle pulse when the access finishes
//   rsp_rdata/rsp_err  extended load data / error flag, valid with rsp_valid
//   stall              core must hold PC and operands
//   mem_req/we/addr/wdata/be  memory request, stable while mem_req=1
//   mem_ack/mem_rdata  memory completion, read data valid with mem_ack
//   dbg_state          current FSM state (0 IDLE, 1 REQ, 2 RESP)
//
// Handshake: a core request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE. The memory side
// holds mem_req and all mem_* fields constant until a cycle with mem_ack=1
// (or until the timeout expires); mem_ack outside REQ is ignored.
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int s              = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_fn3,
    input  logic [s-1:0] req_addr,
    input  logic [s-1:0] req_wdata,
    output logic         rsp_valid,
    output logic [s-1:0] rsp_rdata,
    output logic         rsp_err,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [s-1:0] mem_addr,
    output logic [s-1:0] mem_wdata,
    output logic [3:0]   mem_be,
    input  logic         mem_ack,
    input  logic [s-1:0] mem_rdata,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [2:0]      fn3_q, fn3_d;
    logic [1:0]      off_q, off_d;
    logic [s-1:0]    addr_q, addr_d;
    logic [s-1:0]    wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic [s-1:0]    rdata_q, rdata_d;
    logic            err_q, err_d;

    // Decode of the incoming request (used only on the accept cycle).
    logic            fn3_ok;
    logic            misalign;
    logic            req_legal;
    logic [3:0]      be_new;
    logic [s-1:0]    wdata_new;

    always_comb begin
        fn3_ok = 1'b0;
        if (req_we) begin
            // Stores exist only for byte, half and word sizes.
            fn3_ok = (req_fn3 == 3'b000) || (req_fn3 == 3'b001) || (req_fn3 == 3'b010);
        end else begin
            fn3_ok = (req_fn3 == 3'b000) || (req_fn3 == 3'b001) || (req_fn3 == 3'b010) ||
                     (req_fn3 == 3'b100) || (req_fn3 == 3'b101);
        end

        misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
        case (req_fn3[1:0])
            2'b01:   misalign = req_addr[0];
            2'b10:   misalign = (req_addr[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
`endif

        req_legal = fn3_ok && !misalign;

        be_new    = 4'hF;
        wdata_new = '0;
        if (req_we) begin
            case (req_fn3[1:0])
                2'b00: begin
                    be_new    = 4'b0001 << req_addr[1:0];
                    wdata_new = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    be_new    = 4'b0011 << {req_addr[1], 1'b0};
                    wdata_new = {2{req_wdata[15:0]}};
                end
                default: begin
                    be_new    = 4'hF;
                    wdata_new = req_wdata;
                end
            endcase
        end
    end

    // Load data extraction from the word returned by memory.
    logic [7:0]   byte_sel;
    logic [15:0]  half_sel;
    logic [s-1:0] load_ext;

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (fn3_q)
            3'b000:  load_ext = {{(s-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{(s-16){half_sel[15]}}, half_sel};
            3'b100:  load_ext = {{(s-8){1'b0}}, byte_sel};
            3'b101:  load_ext = {{(s-16){1'b0}}, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        fn3_d   = fn3_q;
        off_d   = off_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    we_d    = req_we;
                    fn3_d   = req_fn3;
                    off_d   = req_addr[1:0];
                    addr_d  = {req_addr[s-1:2], 2'b00};
                    wdata_d = wdata_new;
                    be_d    = be_new;
                    rdata_d = '0;
                    if (req_legal) begin
                        err_d   = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        // Rejected without touching memory.
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end

            ST_REQ: begin
                if (mem_ack) begin
                    rdata_d = we_q ? '0 : load_ext;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // This is the TIMEOUT_CYCLES-th REQ cycle without ack.
                    rdata_d = '0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            fn3_q   <= 3'b000;
            off_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'h0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            fn3_q   <= fn3_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs are decoded from registered state only, except stall, which
    // must react to req_valid in IDLE so the core holds during acceptance.
    logic in_idle, in_req, in_resp;

    always_comb begin
        in_idle   = (state_q == ST_IDLE);
        in_req    = (state_q == ST_REQ);
        in_resp   = (state_q == ST_RESP);

        req_ready = in_idle;
        stall     = reset && ((in_idle && req_valid) || in_req);

        mem_req   = in_req;
        mem_we    = in_req && we_q;
        mem_addr  = in_req ? addr_q  : '0;
        mem_wdata = in_req ? wdata_q : '0;
        mem_be    = in_req ? be_q    : 4'h0;

        rsp_valid = in_resp;
        rsp_rdata = in_resp ? rdata_q : '0;
        rsp_err   = in_resp && err_q;

        dbg_state = state_q;
    end

endmodule
